// File: rtl/seq_gen_pkg.sv
// Shared definitions for the seq_gen serial pattern generator:
// FSM state encoding and default parameter values.
package seq_gen_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_gen_shreg.sv
// Shift/reload datapath for seq_gen: holds the captured pattern and a working
// copy that shifts left, presenting the current bit on msb_o.
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_i,
    input  logic             reload_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] pattern_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shift_q, shift_d;

    // Capture has priority: it loads both the held copy and the working copy.
    always_comb begin
        hold_d  = hold_q;
        shift_d = shift_q;
        if (capture_i) begin
            hold_d  = pattern_i;
            shift_d = pattern_i;
        end else if (reload_i) begin
            shift_d = hold_q;
        end else if (shift_i) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            shift_q <= '0;
        end else begin
            hold_q  <= hold_d;
            shift_q <= shift_d;
        end
    end

    assign msb_o = shift_q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: emits a WIDTH-bit pattern MSB first, reps times,
// then pulses done. Define SEQ_GEN_GAP_EN to insert one idle cycle between repetitions.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SEQ_GEN_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             capture, reload, shift;
    logic             msb;

    seq_gen_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .capture_i (capture),
        .reload_i  (reload),
        .shift_i   (shift),
        .pattern_i (pattern),
        .msb_o     (msb)
    );

    // rep_q counts repetitions still to send, including the current one.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        capture = 1'b0;
        reload  = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        capture = 1'b1;
                        rep_d   = reps;
                        bit_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    if (rep_q == CNT_W'(1)) begin
                        rep_d   = '0;
                        state_d = DONE;
                    end else begin
                        rep_d   = rep_q - CNT_W'(1);
                        reload  = 1'b1;
                        state_d = GAP_EN ? GAP : SHIFT;
                    end
                end else begin
                    bit_d = bit_q + BW'(1);
                    shift = 1'b1;
                end
            end
            GAP:     state_d = SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
        end
    end

    // Outputs decode directly from state so an asynchronous reset clears them at once.
    assign dout_valid = (state_q == SHIFT);
    assign dout       = dout_valid & msb;
    assign busy       = (state_q == SHIFT) || (state_q == GAP);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: queue-based per-cycle reference model plus
// directed scenarios with literal expectations. Honours SEQ_GEN_GAP_EN.
module tb_seq_gen;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic             dout, dout_valid, busy, done;

    seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .reps       (reps),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic d;
        logic v;
        logic b;
        logic dn;
    } obs_t;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue entry per future output cycle.
    obs_t exp_q[$];

    function automatic void build(input logic [WIDTH-1:0] pat, input int r);
        for (int k = 0; k < r; k++) begin
            for (int i = WIDTH - 1; i >= 0; i--)
                exp_q.push_back('{d: pat[i], v: 1'b1, b: 1'b1, dn: 1'b0});
`ifdef SEQ_GEN_GAP_EN
            if (k != r - 1) exp_q.push_back('{d: 1'b0, v: 1'b0, b: 1'b1, dn: 1'b0});
`endif
        end
        exp_q.push_back('{d: 1'b0, v: 1'b0, b: 1'b0, dn: 1'b1});
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) exp_q.delete();
        else if (exp_q.size() != 0) void'(exp_q.pop_front());
        else if (start) build(pattern, int'(reps));
    end

    // Per-scenario observation log.
    logic        log_en = 1'b0;
    logic [63:0] bits;
    int          nbits, busy_cyc, done_cnt, done_idx, first_v, idx;
    logic [63:0] gap_mask;

    task automatic clear_log();
        bits = '0; nbits = 0; busy_cyc = 0; done_cnt = 0;
        done_idx = -1; first_v = -1; idx = 0; gap_mask = '0;
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        a = '{d: dout, v: dout_valid, b: busy, dn: done};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual{d,v,b,done}=%b required=%b", $time, a, e);
        end
        if (log_en) begin
            if (dout_valid) begin
                bits = {bits[62:0], dout};
                nbits++;
                if (first_v < 0) first_v = idx;
            end
            if (busy) busy_cyc++;
            if (busy && !dout_valid) gap_mask[idx] = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = idx;
            end
            idx++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic start_tx(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] r);
        @(posedge clk); #2;
        pattern = pat; reps = r; start = 1'b1;
        clear_log();
        log_en = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int n = 0;
        while (done_cnt == 0 && n < maxc) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_no_timeout"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk);
        #1 log_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; reps = '0;
        #3;
        chk("reset_outputs", {60'd0, dout, dout_valid, busy, done}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single repetition.
        start_tx(4'b1011, 4'd1);
        wait_done("rep1", 20);
        chk("rep1_bits",    bits[3:0], 64'b1011);
        chk("rep1_nbits",   nbits,     64'd4);
        chk("rep1_first",   first_v,   64'd1);
        chk("rep1_done_at", done_idx,  64'd5);
        chk("rep1_done_n",  done_cnt,  64'd1);

        // Three repetitions.
        start_tx(4'b1011, 4'd3);
        wait_done("rep3", 30);
        chk("rep3_bits",  bits[11:0], 64'b101110111011);
        chk("rep3_nbits", nbits,      64'd12);
`ifdef SEQ_GEN_GAP_EN
        chk("rep3_busy",    busy_cyc, 64'd14);
        chk("rep3_gaps",    gap_mask, (64'd1 << 5) | (64'd1 << 10));
        chk("rep3_done_at", done_idx, 64'd15);
`else
        chk("rep3_busy",    busy_cyc, 64'd12);
        chk("rep3_gaps",    gap_mask, 64'd0);
        chk("rep3_done_at", done_idx, 64'd13);
`endif

        // Zero repetitions: done only.
        start_tx(4'b1011, 4'd0);
        wait_done("rep0", 10);
        chk("rep0_done_at", done_idx, 64'd1);
        chk("rep0_nbits",   nbits,    64'd0);
        chk("rep0_busy",    busy_cyc, 64'd0);

        // Start and pattern change while busy are ignored.
        start_tx(4'b1011, 4'd2);
        @(posedge clk); #2;
        start = 1'b1; pattern = 4'b0000; reps = 4'd7;
        repeat (3) @(posedge clk);
        #2 start = 1'b0;
        wait_done("ignore", 30);
        chk("ignore_bits",   bits[7:0], 64'b10111011);
        chk("ignore_nbits",  nbits,     64'd8);
        chk("ignore_done_n", done_cnt,  64'd1);

        // Reset on the second bit.
        start_tx(4'b1011, 4'd2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_dout",  dout,       64'd0);
        chk("rst_valid", dout_valid, 64'd0);
        chk("rst_busy",  busy,       64'd0);
        chk("rst_done",  done,       64'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        #1 log_en = 1'b0;
        chk("rst_nbits",  nbits,    64'd1);
        chk("rst_done_n", done_cnt, 64'd0);

        // Maximum repeat count.
        start_tx(4'b0110, 4'd15);
        wait_done("repmax", 120);
        chk("repmax_nbits", nbits,     64'd60);
        chk("repmax_tail",  bits[7:0], 64'b01100110);
        chk("repmax_done",  done_cnt,  64'd1);

        // Start held high: next transfer accepted the cycle after done.
        @(posedge clk); #2;
        pattern = 4'b1001; reps = 4'd1; start = 1'b1;
        clear_log();
        log_en = 1'b1;
        repeat (12) @(negedge clk);
        #1 start = 1'b0;
        log_en = 1'b0;
        chk("b2b_done_n",  done_cnt,  64'd2);
        chk("b2b_nbits",   nbits,     64'd8);
        chk("b2b_bits",    bits[7:0], 64'b10011001);
        chk("b2b_done_at", done_idx,  64'd5);

        repeat (4) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the pattern length in bits (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the repeat-count width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a transmission.
REQ-006 The block SHALL have port pattern, input, WIDTH bits: the bit sequence to emit, MSB first.
REQ-007 The block SHALL have port reps, input, CNT_W bits: the number of back-to-back pattern repetitions.
REQ-008 The block SHALL have port dout, output, 1 bit: the serial data bit.
REQ-009 The block SHALL have port dout_valid, output, 1 bit: dout carries a pattern bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: a transmission is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, GAP and DONE.
REQ-013 In IDLE with start=1 and reps!=0, the block SHALL capture pattern and reps and move to SHIFT.
REQ-014 In IDLE with start=1 and reps=0, the block SHALL move to DONE without emitting any bits.
REQ-015 The first bit (pattern[WIDTH-1]) SHALL appear on dout with dout_valid=1 in the cycle after start is sampled.
REQ-016 In SHIFT, the block SHALL emit one bit per cycle, MSB to LSB, so each repetition lasts exactly WIDTH cycles.
REQ-017 After the LSB of a repetition that is not the last, the block SHALL restart from the captured MSB, going via GAP when it is enabled (REQ-027) and directly otherwise.
REQ-018 After the LSB of the last repetition, the block SHALL enter DONE, assert done for exactly one cycle, then return to IDLE.
REQ-019 busy SHALL be 1 in SHIFT and GAP, and 0 in IDLE and DONE.
REQ-020 Whenever dout_valid=0, dout SHALL be 0.
REQ-021 While busy=1 or in DONE, start SHALL be ignored, and changes on pattern or reps SHALL NOT affect the transmission in flight.
REQ-022 The internal bit counter SHALL be $clog2(WIDTH) bits wide and SHALL wrap WIDTH-1 -> 0 at the end of each repetition.
REQ-023 The repetition counter SHALL be CNT_W bits wide; reps = 2^CNT_W-1 SHALL be supported without overflow.
REQ-024 The earliest cycle in which a new start can be accepted SHALL be the cycle after done.

Reset
REQ-025 Asserting rst SHALL immediately force the FSM to IDLE, clear all counters and registers, and drive dout, dout_valid, busy and done to 0, including mid-transmission.
REQ-026 After rst deasserts, the block SHALL not emit any bit until a new start is sampled.

Configuration
REQ-027 When macro SEQ_GEN_GAP_EN is defined, the block SHALL insert exactly one GAP cycle (dout=0, dout_valid=0, busy=1) between consecutive repetitions, with no GAP after the last repetition.
REQ-028 When SEQ_GEN_GAP_EN is undefined, the GAP state SHALL be unreachable and repetitions SHALL be contiguous.

Structure
REQ-029 The package seq_gen_pkg SHALL hold the FSM state typedef and the default values of WIDTH and CNT_W.
REQ-030 The shift/reload datapath SHALL be a sub-module, seq_gen_shreg (parallel load, shift left, MSB out); the FSM and counters SHALL stay in seq_gen.

Verification
REQ-031 The bench SHALL check: pattern=1011, reps=1, start pulse -> dout 1,0,1,1 on the 4 cycles after start with dout_valid=1, then done=1 for one cycle.
REQ-032 The bench SHALL check: pattern=1011, reps=3, gap off -> 12 contiguous valid bits 101110111011, then done.
REQ-033 The bench SHALL check: same stimulus with SEQ_GEN_GAP_EN -> 1011,gap,1011,gap,1011, i.e. 14 busy cycles with dout_valid=0 on cycles 5 and 10.
REQ-034 The bench SHALL check: reps=0, start -> done pulse the next cycle, with dout_valid never asserted and busy never asserted.
REQ-035 The bench SHALL check: start re-asserted and pattern changed to 0000 mid-transmission -> output unchanged, exactly one done pulse.
REQ-036 The bench SHALL check: rst asserted on the 2nd bit of reps=2 -> all outputs 0 in the same cycle, then idle until the next start.
